// File: rtl/pc_sequencer.sv
// Program counter sequencer for the MIPS pipeline. Picks the next fetch
// address from sequential, branch, jump and register targets, and drives the IF/ID flush.
module pc_sequencer #(
  parameter int unsigned PC_SIZE    = 32,
  parameter int unsigned PC_STEP    = 4,
  parameter int unsigned COUNT_SIZE = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_stall,
  input  logic                  i_halt,
  input  logic                  i_jump,
  input  logic [PC_SIZE-1:0]    i_jump_addr,
  input  logic                  i_jr,
  input  logic [PC_SIZE-1:0]    i_jr_addr,
  input  logic                  i_branch_taken,
  input  logic [PC_SIZE-1:0]    i_branch_addr,
  output logic [PC_SIZE-1:0]    o_pc,
  output logic [PC_SIZE-1:0]    o_pc_plus4,
  output logic                  o_flush,
  output logic                  o_halted,
  output logic                  o_misaligned,
  output logic [COUNT_SIZE-1:0] o_fetch_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                r_state;
  logic [PC_SIZE-1:0]    r_pc;
  logic                  r_flush;
  logic                  r_halted;
  logic                  r_misaligned;
  logic [COUNT_SIZE-1:0] r_count;

  logic                  w_redirect;
  logic [PC_SIZE-1:0]    w_target;
  logic [PC_SIZE-1:0]    w_pc_seq;
  logic [COUNT_SIZE-1:0] w_count_inc;

  // Redirect source selection: jr beats jump beats branch.
  always_comb begin
    w_redirect = i_jr | i_jump | i_branch_taken;
    w_target   = i_branch_addr;
    if (i_jr) begin
      w_target = i_jr_addr;
    end else if (i_jump) begin
      w_target = i_jump_addr;
    end
  end

  assign w_pc_seq    = r_pc + PC_SIZE'(PC_STEP);
  assign w_count_inc = r_count + COUNT_SIZE'(1);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_RUN;
      r_pc         <= '0;
      r_flush      <= 1'b0;
      r_halted     <= 1'b0;
      r_misaligned <= 1'b0;
      r_count      <= '0;
    end else if (i_enable) begin
      case (r_state)
        ST_RUN: begin
          r_flush <= 1'b0;
          if (i_halt) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else if (i_stall) begin
            r_pc <= r_pc;
          end else if (w_redirect) begin
            r_pc    <= {w_target[PC_SIZE-1:2], 2'b00};
            r_flush <= 1'b1;
            r_state <= ST_FLUSH;
            r_count <= w_count_inc;
            if (w_target[1:0] != 2'b00) begin
              r_misaligned <= 1'b1;
            end
          end else begin
            r_pc    <= w_pc_seq;
            r_count <= w_count_inc;
          end
        end
        // ID holds a bubble here, so only the stall matters.
        ST_FLUSH: begin
          r_flush <= 1'b0;
          r_state <= ST_RUN;
          if (!i_stall) begin
            r_pc    <= w_pc_seq;
            r_count <= w_count_inc;
          end
        end
        ST_HALTED: begin
          r_flush  <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_pc_plus4    = r_pc + PC_SIZE'(PC_STEP);
  assign o_flush       = r_flush;
  assign o_halted      = r_halted;
  assign o_misaligned  = r_misaligned;
  assign o_fetch_count = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic checked
// against a behavioural model of the fetch sequencing rules.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_addr = '0;
  logic        br = 1'b0;
  logic [31:0] br_addr = '0;

  logic [31:0] pc, pc_plus4, fcount;
  logic        flush, halted, mis;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc = '0;
  logic [31:0] m_cnt = '0;
  bit          m_in_flush = 0;
  bit          m_halted = 0;
  bit          m_mis = 0;

  pc_sequencer #(.PC_SIZE(32), .PC_STEP(4), .COUNT_SIZE(32)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_stall(stall), .i_halt(halt),
    .i_jump(jump), .i_jump_addr(jump_addr), .i_jr(jr), .i_jr_addr(jr_addr),
    .i_branch_taken(br), .i_branch_addr(br_addr),
    .o_pc(pc), .o_pc_plus4(pc_plus4), .o_flush(flush), .o_halted(halted),
    .o_misaligned(mis), .o_fetch_count(fcount)
  );

  always #5 clk = ~clk;

  // One clock of the sequencing rules, using the inputs present at the edge.
  task automatic model_update();
    logic [31:0] t;
    if (rst) begin
      m_pc = 0; m_cnt = 0; m_in_flush = 0; m_halted = 0; m_mis = 0;
    end else if (en) begin
      if (m_halted) begin
        m_in_flush = 0;
      end else if (m_in_flush) begin
        m_in_flush = 0;
        if (!stall) begin m_pc = m_pc + 4; m_cnt = m_cnt + 1; end
      end else if (halt) begin
        m_halted = 1;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (jr || jump || br) begin
        t = jr ? jr_addr : (jump ? jump_addr : br_addr);
        if (t % 4 != 0) m_mis = 1;
        m_pc = t - (t % 4);
        m_in_flush = 1;
        m_cnt = m_cnt + 1;
      end else begin
        m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic idle();
    rst = 0; en = 1; stall = 0; halt = 0; jump = 0; jr = 0; br = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1; step(); rst = 0;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (flush !== 1'b0 || halted !== 1'b0 || mis !== 1'b0) begin
      errors++; $display("FAIL reset_flags got f%b h%b m%b want 000", flush, halted, mis); end
    checks++; if (fcount !== 32'h0) begin errors++; $display("FAIL reset_count got %0d want 0", fcount); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_plus4 got %h want 4", pc_plus4); end
  endtask

  task automatic test_sequential();
    idle();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (pc !== 32'(4 * k) || flush !== 1'b0) begin
        errors++; $display("FAIL seq_pc%0d got %h f%b want %h f0", k, pc, flush, 4 * k); end
    end
    checks++; if (fcount !== 32'd4) begin errors++; $display("FAIL seq_count got %0d want 4", fcount); end
  endtask

  task automatic test_jump();
    idle(); jump = 1; jump_addr = 32'h0040_0020; step(); idle();
    checks++; if (pc !== 32'h0040_0020 || flush !== 1'b1) begin
      errors++; $display("FAIL jump_target got %h f%b want 00400020 f1", pc, flush); end
    step();
    checks++; if (pc !== 32'h0040_0024 || flush !== 1'b0) begin
      errors++; $display("FAIL jump_next got %h f%b want 00400024 f0", pc, flush); end
  endtask

  task automatic test_priority();
    idle(); jr = 1; jr_addr = 32'h100; jump = 1; jump_addr = 32'h200; br = 1; br_addr = 32'h300;
    step(); idle();
    checks++; if (pc !== 32'h100 || flush !== 1'b1) begin
      errors++; $display("FAIL prio_jr got %h f%b want 100 f1", pc, flush); end
    step();
    jr = 1; jump = 1; br = 1; stall = 1; step(); idle();
    checks++; if (pc !== 32'h104 || flush !== 1'b0) begin
      errors++; $display("FAIL prio_stall got %h f%b want 104 f0", pc, flush); end
  endtask

  task automatic test_flush_enable();
    logic [31:0] c;
    idle(); jump = 1; jump_addr = 32'h400; step(); idle();
    br = 1; br_addr = 32'h500; step(); idle();
    checks++; if (pc !== 32'h404 || flush !== 1'b0) begin
      errors++; $display("FAIL flush_ignore got %h f%b want 404 f0", pc, flush); end
    jump = 1; jump_addr = 32'h800; step(); idle();
    c = m_cnt;
    en = 0;
    for (int k = 0; k < 3; k++) begin
      jr = 1'($urandom); jr_addr = $urandom; halt = 1'($urandom); br = 1; br_addr = $urandom;
      step();
      checks++; if (pc !== 32'h800 || flush !== 1'b1 || fcount !== c || halted !== 1'b0) begin
        errors++; $display("FAIL freeze%0d got %h f%b c%0d want 800 f1 c%0d", k, pc, flush, fcount, c); end
    end
    idle(); step();
    checks++; if (pc !== 32'h804 || flush !== 1'b0) begin
      errors++; $display("FAIL unfreeze got %h f%b want 804 f0", pc, flush); end
  endtask

  task automatic test_halt();
    logic [31:0] c;
    idle(); jump = 1; jump_addr = 32'h1C; step(); idle(); step();
    halt = 1; step(); idle();
    checks++; if (pc !== 32'h20 || halted !== 1'b1 || flush !== 1'b0) begin
      errors++; $display("FAIL halt_enter got %h h%b f%b want 20 h1 f0", pc, halted, flush); end
    c = m_cnt;
    for (int k = 0; k < 3; k++) begin
      jump = 1; jump_addr = 32'h999 + 32'(k); br = 1; br_addr = 32'h40; step();
    end
    idle();
    checks++; if (pc !== 32'h20 || halted !== 1'b1 || fcount !== c) begin
      errors++; $display("FAIL halt_hold got %h h%b c%0d want 20 h1 c%0d", pc, halted, fcount, c); end
    rst = 1; step(); rst = 0;
    checks++; if (pc !== 0 || halted !== 0 || flush !== 0 || mis !== 0 || fcount !== 0) begin
      errors++; $display("FAIL halt_reset got %h h%b f%b m%b c%0d want all 0", pc, halted, flush, mis, fcount); end
    step();
    checks++; if (pc !== 32'h4 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_resume got %h h%b want 4 h0", pc, halted); end
  endtask

  task automatic test_misaligned_wrap();
    idle(); br = 1; br_addr = 32'h13; step(); idle();
    checks++; if (pc !== 32'h10 || mis !== 1'b1) begin
      errors++; $display("FAIL misaligned got %h m%b want 10 m1", pc, mis); end
    step();
    checks++; if (pc !== 32'h14 || mis !== 1'b1) begin
      errors++; $display("FAIL mis_sticky got %h m%b want 14 m1", pc, mis); end
    jump = 1; jump_addr = 32'hFFFF_FFF8; step(); idle(); step();
    checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL wrap_pre got %h p4 %h want fffffffc p4 0", pc, pc_plus4); end
    step();
    checks++; if (pc !== 32'h0 || mis !== 1'b1) begin
      errors++; $display("FAIL wrap got %h m%b want 0 m1", pc, mis); end
  endtask

  task automatic test_random();
    bit prev_flush = 0;
    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(0, 99) < 2);
      en    = ($urandom_range(0, 99) < 85);
      stall = ($urandom_range(0, 99) < 15);
      halt  = ($urandom_range(0, 99) < 3);
      jr    = ($urandom_range(0, 99) < 10);
      jump  = ($urandom_range(0, 99) < 10);
      br    = ($urandom_range(0, 99) < 15);
      jr_addr = $urandom; jump_addr = $urandom; br_addr = $urandom;
      step();
      checks++;
      if (pc !== m_pc || flush !== 1'(m_in_flush) || halted !== 1'(m_halted) ||
          mis !== 1'(m_mis) || fcount !== m_cnt || pc_plus4 !== m_pc + 32'd4) begin
        errors++;
        $display("FAIL rand%0d got pc %h f%b h%b m%b c%0d want pc %h f%b h%b m%b c%0d",
                 k, pc, flush, halted, mis, fcount, m_pc, m_in_flush, m_halted, m_mis, m_cnt);
      end
      if (en && !rst) begin
        checks++;
        if (prev_flush && flush) begin errors++; $display("FAIL rand_double_flush at %0d got 11 want not 11", k); end
        prev_flush = flush;
      end else if (rst) begin
        prev_flush = 0;
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_priority();
    test_flush_enable();
    test_halt();
    test_misaligned_wrap();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
